fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RV32I core. It owns the PC and issues word requests to instruction memory over a valid/ready handshake. It buffers in-order responses in a 2-entry FIFO and presents `Instr` plus its PC to decode, which drives the immediate extender and control logic. Control-flow redirects from execute flush the FIFO and discard in-flight responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: address of the first fetch after reset.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `imem_req_valid` output 1: fetch request pending.
- `imem_req_ready` input 1: memory accepts the request this cycle.
- `imem_req_addr` output 32: word address of the request; bits [1:0] are always 0.
- `imem_rsp_valid` input 1: response data valid. Responses arrive in request order, one per accepted request, no earlier than 1 cycle after acceptance.
- `imem_rsp_data` input 32: instruction word.
- `redirect_valid` input 1: branch/jump taken; load a new PC.
- `redirect_pc` input 32: target; bits [1:0] are forced to 0 internally.
- `instr_valid` output 1: FIFO head is valid.
- `instr_ready` input 1: decode consumes the head this cycle.
- `Instr` output 32: FIFO head instruction; 32'h0000_0013 (NOP) when empty.
- `instr_pc` output 32: PC of `Instr`; 0 when empty.

## Operation
- State: `pc` (32), FIFO of 2 entries {instr, pc}, `count` (0..2), `inflight` (0..2), `drop` (0..2), FSM {RUN, DRAIN}.
- Accept = `imem_req_valid && imem_req_ready`. Pop = `instr_valid && instr_ready`.
- `imem_req_valid` = (state==RUN) && !`redirect_valid` && (`inflight` + `count` − Pop < 2). This is combinational.
- `imem_req_addr` = `pc`. `pc` changes only on Accept (`pc`+4, wrapping modulo 2^32) or on redirect. The address is therefore stable while a request is held un-accepted.
- A request may be withdrawn only in a redirect cycle. Memory treats only Accept as a transfer.
- Response handling in RUN: the response is written to the FIFO tail with the PC recorded at issue. A 2-entry issue-PC queue travels alongside `inflight`. The credit rule guarantees the FIFO never overflows.
- `inflight` is incremented on Accept and decremented on each response. Accept and response in the same cycle leave it unchanged.
- Redirect (highest priority, any state):
  - FIFO is emptied (`count`=0).
  - `pc` = {`redirect_pc`[31:2], 2'b00}.
  - `drop` = `inflight` − (response this cycle ? 1 : 0).
  - Next state: DRAIN if that `drop` value is nonzero, else RUN.
  - A response arriving in the redirect cycle is discarded.
  - A Pop in the redirect cycle still completes at the decode side. The FIFO is cleared regardless.
- DRAIN: no requests are issued. Each response decrements `drop` and `inflight` and is not written. When `drop` reaches 0, return to RUN on the next cycle. A new redirect in DRAIN re-applies the redirect rules.
- FIFO is first-in first-out. Pop and write in the same cycle are both allowed at any count, including 2 (pop then write).

## Timing
- Reset (async assert, regardless of clock):
  - `pc`=RESET_PC, `count`=0, `inflight`=0, `drop`=0, state=RUN.
  - `instr_valid`=0, `Instr`=32'h0000_0013, `instr_pc`=0.
  - `imem_req_valid`=1 in the first cycle after `rst_n` deasserts, with `imem_req_addr`=RESET_PC.
- Reset asserted mid-operation discards all in-flight state. Memory must also be reset, so that no stale responses arrive.
- Response to `instr_valid` latency: 1 cycle (registered FIFO write, head visible the next cycle).
- Throughput: with 1-cycle memory latency and `instr_ready`=1, one instruction per cycle in steady state.
- Redirect to first new request: 0 cycles if nothing is in flight (request issued the cycle after redirect). Otherwise, the cycle after the last dropped response.
- `Instr`/`instr_pc` are held stable while `instr_valid`=1 and `instr_ready`=0.

## Test plan
- Reset release, memory always ready, 1-cycle latency, `instr_ready`=1 -> requests at 0x0, 0x4, 0x8 … on consecutive cycles. `instr_valid` rises on cycle 3 with `instr_pc`=0x0, then one instruction per cycle.
- `instr_ready`=0 after reset -> exactly 2 requests accepted, `imem_req_valid` then stays 0. On raising `instr_ready`, pops return PCs 0x0 and 0x4 in order and fetching resumes at 0x8.
- `imem_req_ready`=0 for 5 cycles -> `imem_req_valid`=1 with `imem_req_addr` held at RESET_PC for all 5 cycles, and exactly one accept when ready rises.
- Redirect to 0x1002 with 2 requests in flight (3-cycle latency) -> FIFO empties, the 2 old responses are dropped, and the next request address is 0x1000. The first delivered `instr_pc` is 0x1000.
- Redirect in the same cycle as a response, with 1 in flight -> the response is discarded, the FSM stays RUN, and the next cycle requests the target.
- Assert `rst_n`=0 mid-stream with the FIFO full -> `instr_valid`=0, `Instr`=0x0000_0013 and `instr_pc`=0 immediately, without a clock edge. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: owns the PC, issues word requests to instruction
// memory, buffers in-order responses in a 2-entry FIFO and drops responses made stale by redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] Instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 2;
  localparam logic [CW:0]     DEPTH     = 3'd2;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            fifo_rd_q, fifo_rd_d;
  logic            fifo_wr_q, fifo_wr_d;
  logic            ipc_rd_q, ipc_rd_d;
  logic            ipc_wr_q, ipc_wr_d;

  logic [XLEN-1:0] fifo_instr_q [2];
  logic [XLEN-1:0] fifo_pc_q    [2];
  logic [XLEN-1:0] ipc_q        [2];

  logic            accept;
  logic            pop;
  logic            rsp;
  logic            fifo_write;
  logic [CW:0]     credit_used;

  // A response with nothing outstanding is a protocol error; ignore it rather than corrupt counters.
  assign rsp        = imem_rsp_valid && (inflight_q != '0);
  assign pop        = instr_valid && instr_ready;
  assign accept     = imem_req_valid && imem_req_ready;
  assign fifo_write = rsp && (state_q == ST_RUN) && !redirect_valid;

  // Credit check inflight + count - pop < 2, with pop moved to the right side to avoid underflow.
  assign credit_used    = {1'b0, inflight_q} + {1'b0, count_q};
  assign imem_req_valid = (state_q == ST_RUN) && !redirect_valid &&
                          (credit_used < (DEPTH + {{CW{1'b0}}, pop}));
  assign imem_req_addr  = pc_q;

  assign instr_valid = (count_q != '0);
  assign Instr       = instr_valid ? fifo_instr_q[fifo_rd_q] : NOP_INSTR;
  assign instr_pc    = instr_valid ? fifo_pc_q[fifo_rd_q] : '0;

  // Next-state logic; redirect overrides everything else.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    drop_d     = drop_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_wr_d  = fifo_wr_q;
    ipc_rd_d   = ipc_rd_q ^ rsp;
    ipc_wr_d   = ipc_wr_q ^ accept;
    inflight_d = inflight_q + CW'(accept) - CW'(rsp);

    if (redirect_valid) begin
      pc_d      = redirect_pc & ~XLEN'(3);
      count_d   = '0;
      fifo_rd_d = 1'b0;
      fifo_wr_d = 1'b0;
      drop_d    = inflight_q - CW'(rsp);
      state_d   = (drop_d != '0) ? ST_DRAIN : ST_RUN;
    end else begin
      if (accept) begin
        pc_d = pc_q + PC_STEP;
      end
      if (pop) begin
        fifo_rd_d = ~fifo_rd_q;
      end
      if (fifo_write) begin
        fifo_wr_d = ~fifo_wr_q;
      end
      count_d = count_q + CW'(fifo_write) - CW'(pop);
      if ((state_q == ST_DRAIN) && rsp) begin
        drop_d = drop_q - CW'(1);
        if (drop_q == CW'(1)) begin
          state_d = ST_RUN;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      fifo_rd_q  <= 1'b0;
      fifo_wr_q  <= 1'b0;
      ipc_rd_q   <= 1'b0;
      ipc_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      ipc_rd_q   <= ipc_rd_d;
      ipc_wr_q   <= ipc_wr_d;
    end
  end

  // Payload storage needs no reset: occupancy counters gate every read.
  always_ff @(posedge clk) begin
    if (fifo_write) begin
      fifo_instr_q[fifo_wr_q] <= imem_rsp_data;
      fifo_pc_q[fifo_wr_q]    <= ipc_q[ipc_rd_q];
    end
    if (accept) begin
      ipc_q[ipc_wr_q] <= pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency-programmable memory model plus an
// expected-instruction scoreboard filled on request acceptance and drained on decode pops.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] Instr;
  logic [31:0] instr_pc;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  pend_t       pend[$];
  exp_t        exp_q[$];
  int unsigned cyc     = 0;
  int unsigned lat     = 1;
  int unsigned acc_cnt = 0;
  int unsigned pop_cnt = 0;
  int unsigned total   = 0;
  int unsigned passed  = 0;
  int unsigned p0;
  logic        mem_ready;
  logic [31:0] exp_pc = RESET_PC;
  logic        seen;

  assign imem_req_ready = mem_ready;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .Instr          (Instr),
    .instr_pc       (instr_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Memory model and scoreboard: drive responses at negedge, sample handshakes just before posedge.
  initial begin
    exp_t e;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && (pend.size() > 0) && (pend[0].due <= cyc)) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_data(pend[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
      #4;
      if (!rst_n) begin
        pend.delete();
        exp_q.delete();
        exp_pc  = RESET_PC;
        acc_cnt = 0;
        pop_cnt = 0;
      end else begin
        if (instr_valid && instr_ready) begin
          pop_cnt++;
          if (exp_q.size() == 0) begin
            chk("pop_unexpected", instr_pc, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("pop_instr", Instr, e.data);
            chk("pop_pc", instr_pc, e.pc);
          end
        end else if (!instr_valid) begin
          chk("idle_instr", Instr, NOP);
          chk("idle_pc", instr_pc, 32'h0);
        end
        if (imem_rsp_valid) begin
          void'(pend.pop_front());
        end
        if (redirect_valid) begin
          exp_q.delete();
          exp_pc = {redirect_pc[31:2], 2'b00};
        end
        if (imem_req_valid && imem_req_ready) begin
          acc_cnt++;
          chk("req_addr", imem_req_addr, exp_pc);
          pend.push_back(pend_t'{imem_req_addr, cyc + lat});
          exp_q.push_back(exp_t'{exp_pc, mem_data(exp_pc)});
          exp_pc = exp_pc + 32'd4;
        end
      end
      cyc++;
    end
  end

  // Hold reset two cycles, then release on a negedge; the release cycle is cycle 1.
  task automatic reset_dut(input int unsigned l, input logic mr, input logic ir);
    @(negedge clk);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    lat            = l;
    mem_ready      = mr;
    instr_ready    = ir;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    mem_ready      = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1;
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", Instr, NOP);
    chk("rst_instr_pc", instr_pc, 32'h0);

    // Streaming: one instruction per cycle, first valid in cycle 3.
    reset_dut(1, 1'b1, 1'b1);
    #1;
    chk("t1_req_valid", 32'(imem_req_valid), 32'h1);
    chk("t1_req_addr", imem_req_addr, RESET_PC);
    chk("t1_c1_valid", 32'(instr_valid), 32'h0);
    @(negedge clk); #1;
    chk("t1_c2_valid", 32'(instr_valid), 32'h0);
    @(negedge clk); #1;
    chk("t1_c3_valid", 32'(instr_valid), 32'h1);
    chk("t1_c3_pc", instr_pc, 32'h0);
    p0 = pop_cnt;
    repeat (10) @(negedge clk);
    #1;
    chk("t1_throughput", 32'(pop_cnt - p0), 32'd10);

    // Decode stalled: exactly two requests, then fetch resumes at 0x8.
    reset_dut(1, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    #1;
    chk("t2_accepts", 32'(acc_cnt), 32'd2);
    chk("t2_req_valid", 32'(imem_req_valid), 32'h0);
    chk("t2_head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("t2_pops", 32'(pop_cnt), 32'd2);
    repeat (6) @(negedge clk);

    // Memory back-pressure: address held while un-accepted.
    reset_dut(1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_hold_valid", 32'(imem_req_valid), 32'h1);
      chk("t3_hold_addr", imem_req_addr, RESET_PC);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("t3_one_accept", 32'(acc_cnt), 32'd1);
    repeat (2) @(negedge clk);
    #1;
    chk("t3_still_one", 32'(acc_cnt), 32'd1);
    mem_ready = 1'b1;
    repeat (8) @(negedge clk);

    // Redirect with two requests in flight under 3-cycle latency.
    reset_dut(3, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1002;
    #1;
    chk("t4_redir_req_valid", 32'(imem_req_valid), 32'h0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("t4_drain1_req_valid", 32'(imem_req_valid), 32'h0);
    @(negedge clk); #1;
    chk("t4_drain2_req_valid", 32'(imem_req_valid), 32'h0);
    @(negedge clk); #1;
    chk("t4_new_req_valid", 32'(imem_req_valid), 32'h1);
    chk("t4_new_req_addr", imem_req_addr, 32'h0000_1000);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk); #1;
      if (instr_valid) seen = 1'b1;
    end
    chk("t4_first_pc", seen ? instr_pc : 32'hDEAD_DEAD, 32'h0000_1000);
    repeat (4) @(negedge clk);

    // Redirect coinciding with the only outstanding response.
    reset_dut(2, 1'b1, 1'b1);
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    mem_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    #1;
    chk("t5_rsp_present", 32'(imem_rsp_valid), 32'h1);
    chk("t5_redir_req_valid", 32'(imem_req_valid), 32'h0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("t5_next_req_valid", 32'(imem_req_valid), 32'h1);
    chk("t5_next_req_addr", imem_req_addr, 32'h0000_2000);
    chk("t5_discarded", 32'(instr_valid), 32'h0);
    repeat (6) @(negedge clk);

    // Asynchronous reset with the FIFO full.
    reset_dut(1, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    chk("t6_full_valid", 32'(instr_valid), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(instr_valid), 32'h0);
    chk("t6_async_instr", Instr, NOP);
    chk("t6_async_pc", instr_pc, 32'h0);
    repeat (2) @(negedge clk);
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    #1;
    chk("t6_restart_valid", 32'(imem_req_valid), 32'h1);
    chk("t6_restart_addr", imem_req_addr, RESET_PC);
    repeat (8) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
